// File: rtl/hdmi_i2c_init_sequencer.sv
// HDMI transmitter bring-up sequencer: waits out the power-up delay, then
// walks an external register table and issues one 24-bit I2C write per
// entry, retrying on NACK or controller timeout.
//
// Handshake with the I2C controller: I2C_GO is a registered level request
// that rises on entry to REQ. The controller answers with I2C_END held high
// until I2C_GO drops; I2C_ACK is sampled in the same cycle that I2C_END is
// first seen. A new request is only raised after I2C_END has been seen low,
// and LOAD always separates attempts with a cycle of I2C_GO low.
module hdmi_i2c_init_sequencer #(
    parameter int          LUT_SIZE       = 31,
    parameter logic [7:0]  SLAVE_ADDR     = 8'h72,
    parameter logic [23:0] INIT_DELAY     = 24'd50000,
    parameter logic [15:0] SETTLE_CYCLES  = 16'd100,
    parameter int          RETRY_MAX      = 3,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd200000
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        REINIT,
    output logic [5:0]  LUT_INDEX,
    input  logic [15:0] LUT_DATA,
    output logic [23:0] I2C_DATA,
    output logic        I2C_GO,
    input  logic        I2C_END,
    input  logic        I2C_ACK,
    output logic        BUSY,
    output logic        CONFIG_DONE,
    output logic        CONFIG_ERROR,
    output logic [5:0]  ERR_INDEX
);

    typedef enum logic [2:0] {
        S_PWR_WAIT, S_LOAD, S_REQ, S_REL, S_SETTLE, S_NEXT, S_DONE, S_ERROR
    } state_t;

    localparam logic [24:0] INIT_LIM   = {1'b0, INIT_DELAY};
    localparam logic [24:0] SETTLE_LIM = {9'd0, SETTLE_CYCLES};
    localparam logic [24:0] TMO_LIM    = {1'b0, TIMEOUT_CYCLES};
    localparam logic [5:0]  LAST_INDEX = 6'(LUT_SIZE - 1);
    localparam logic [2:0]  RETRY_LIM  = 3'(RETRY_MAX);

    // state is kept as a named signal so checkers can bind to it directly
    state_t      state, state_n;
    logic [23:0] cnt, cnt_n, cnt_inc;
    logic [24:0] cnt_p1;
    logic [2:0]  retry, retry_n;
    logic        fail, fail_n;
    logic [5:0]  index_n, err_index_n;
    logic [23:0] data_n;
    logic        go_n, busy_n, done_n, error_n;

    // shared delay/settle/timeout counter: saturating increment, and the
    // "limit reached" test is done on cnt+1 so a limit of N takes N cycles
    always_comb begin
        cnt_inc = (cnt == 24'hFFFFFF) ? cnt : cnt + 24'd1;
        cnt_p1  = {1'b0, cnt} + 25'd1;
    end

    // state register
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) state <= S_PWR_WAIT;
        else          state <= state_n;
    end

    // next-state and next-value logic for every register
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        retry_n     = retry;
        fail_n      = fail;
        index_n     = LUT_INDEX;
        data_n      = I2C_DATA;
        busy_n      = BUSY;
        done_n      = CONFIG_DONE;
        error_n     = CONFIG_ERROR;
        err_index_n = ERR_INDEX;
        case (state)
            S_PWR_WAIT: begin
                // the delay only starts once a previous transfer has released I2C_END
                if (I2C_END) begin
                    cnt_n = '0;
                end else if (cnt_p1 >= INIT_LIM) begin
                    cnt_n   = '0;
                    state_n = S_LOAD;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_LOAD: begin
                data_n  = {SLAVE_ADDR, LUT_DATA};
                cnt_n   = '0;
                fail_n  = 1'b0;
                state_n = S_REQ;
            end
            S_REQ: begin
                if (I2C_END) begin
                    fail_n  = I2C_ACK;
                    state_n = S_REL;
                end else if (cnt_p1 >= TMO_LIM) begin
                    fail_n  = 1'b1;
                    state_n = S_REL;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_REL: begin
                if (!I2C_END) begin
                    cnt_n = '0;
                    if (!fail) begin
                        retry_n = '0;
                        state_n = S_SETTLE;
                    end else if (retry < RETRY_LIM) begin
                        retry_n = retry + 3'd1;
                        state_n = S_SETTLE;
                    end else begin
                        err_index_n = LUT_INDEX;
                        error_n     = 1'b1;
                        busy_n      = 1'b0;
                        state_n     = S_ERROR;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_p1 >= SETTLE_LIM) begin
                    cnt_n   = '0;
                    state_n = S_NEXT;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_NEXT: begin
                if (fail) begin
                    state_n = S_LOAD;
                end else if (LUT_INDEX == LAST_INDEX) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = S_DONE;
                end else begin
                    index_n = LUT_INDEX + 6'd1;
                    state_n = S_LOAD;
                end
            end
            default: begin
                state_n = state;
            end
        endcase
        // restart request overrides whatever the current state decided
        if (REINIT) begin
            state_n     = S_PWR_WAIT;
            cnt_n       = '0;
            retry_n     = '0;
            fail_n      = 1'b0;
            index_n     = '0;
            busy_n      = 1'b1;
            done_n      = 1'b0;
            error_n     = 1'b0;
            err_index_n = '0;
        end
        go_n = (state_n == S_REQ);
    end

    // datapath and output registers
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt          <= '0;
            retry        <= '0;
            fail         <= 1'b0;
            LUT_INDEX    <= '0;
            I2C_DATA     <= '0;
            I2C_GO       <= 1'b0;
            BUSY         <= 1'b1;
            CONFIG_DONE  <= 1'b0;
            CONFIG_ERROR <= 1'b0;
            ERR_INDEX    <= '0;
        end else begin
            cnt          <= cnt_n;
            retry        <= retry_n;
            fail         <= fail_n;
            LUT_INDEX    <= index_n;
            I2C_DATA     <= data_n;
            I2C_GO       <= go_n;
            BUSY         <= busy_n;
            CONFIG_DONE  <= done_n;
            CONFIG_ERROR <= error_n;
            ERR_INDEX    <= err_index_n;
        end
    end

endmodule

// File: doc/hdmi_i2c_init_sequencer.md
Name: hdmi_i2c_init_sequencer

Overview:
- Walks a register-write table and drives the 24-bit I2C write controller (CLOCK/GO/END/ACK handshake) to bring up the HDMI transmitter after reset or on request.
- Inserts a power-up delay, issues one 2-byte write per table entry, retries on NACK or timeout, and reports completion or failure.
- Sits between the top-level HDMI overlay logic and the I2C controller; the table is an external combinational ROM indexed by this block.

Parameters:
- LUT_SIZE, 31, number of table entries; valid indices 0..LUT_SIZE-1; range 1..64.
- SLAVE_ADDR, 8'h72, 8-bit write address placed in I2C_DATA[23:16].
- INIT_DELAY, 24'd50000, CLOCK cycles to wait after reset or REINIT before the first write.
- SETTLE_CYCLES, 16'd100, idle CLOCK cycles between consecutive writes.
- RETRY_MAX, 3, retries per entry after the first attempt; range 0..7.
- TIMEOUT_CYCLES, 24'd200000, maximum cycles to wait for I2C_END high.

Ports:
- CLOCK  in  1  block clock; same clock as the I2C controller.
- RESET_N  in  1  asynchronous active-low reset.
- REINIT  in  1  single-cycle pulse; restarts the full sequence from INIT_DELAY.
- LUT_INDEX  out  6  current table index.
- LUT_DATA  in  16  {reg_addr[15:8], reg_data[7:0]} for LUT_INDEX; valid in the same cycle.
- I2C_DATA  out  24  {SLAVE_ADDR, LUT_DATA}, registered.
- I2C_GO  out  1  level request to the I2C controller.
- I2C_END  in  1  controller done; high until I2C_GO drops.
- I2C_ACK  in  1  sampled when I2C_END is high; 1 = NACK seen.
- BUSY  out  1  high from reset release until DONE or ERROR.
- CONFIG_DONE  out  1  sticky; all entries written successfully.
- CONFIG_ERROR  out  1  sticky; an entry exhausted its retries.
- ERR_INDEX  out  6  index of the failing entry; valid while CONFIG_ERROR is high.

Behaviour:
- Reset values: LUT_INDEX=0, I2C_DATA=0, I2C_GO=0, BUSY=1, CONFIG_DONE=0, CONFIG_ERROR=0, ERR_INDEX=0, all counters 0, state=PWR_WAIT.
- PWR_WAIT: count INIT_DELAY cycles, then go to LOAD.
- LOAD (1 cycle): I2C_DATA <= {SLAVE_ADDR, LUT_DATA}; go to REQ.
- REQ: I2C_GO=1 from the first REQ cycle.
  - On I2C_END=1: drop I2C_GO the next cycle; capture I2C_ACK; go to REL.
  - If TIMEOUT_CYCLES elapse with no I2C_END: drop I2C_GO; the attempt counts as failed; go to REL.
- REL: hold I2C_GO=0 until I2C_END=0; a timed-out attempt passes through immediately if I2C_END is already 0.
  - Success (ACK=0, no timeout): clear the retry counter, go to SETTLE.
  - Failure with retries < RETRY_MAX: increment retries, go to SETTLE, then repeat LOAD with the same index.
  - Failure with retries = RETRY_MAX: set ERR_INDEX=LUT_INDEX and CONFIG_ERROR=1, BUSY=0, go to ERROR.
- SETTLE: count SETTLE_CYCLES, then go to NEXT.
- NEXT:
  - After a success: if LUT_INDEX = LUT_SIZE-1, set CONFIG_DONE=1 and BUSY=0, go to DONE; otherwise increment LUT_INDEX and go to LOAD.
  - After a failure that is being retried: go to LOAD without changing the index.
- DONE / ERROR: I2C_GO=0; hold all outputs.
- REINIT, from any state: accepted on the next clock edge.
  - Clear CONFIG_DONE, CONFIG_ERROR, ERR_INDEX, LUT_INDEX and the retry counter; set BUSY=1; go to PWR_WAIT.
  - If REINIT arrives mid-transaction (REQ/REL), drop I2C_GO immediately and wait for I2C_END=0 before the PWR_WAIT count starts.
- Asynchronous reset mid-transaction: I2C_GO=0 at once; no partial-state recovery.
- I2C_GO is never reasserted while I2C_END=1. At least one cycle with I2C_GO=0 separates attempts.
- Counters saturate and do not wrap. A LUT_INDEX increment past LUT_SIZE-1 is impossible by construction.
- Latency per successful entry: 1 (LOAD) + controller time + 1 (GO drop) + REL wait + SETTLE_CYCLES + 1 (NEXT).

Test Plan:
- Bench setup: LUT_SIZE=4, INIT_DELAY=10, SETTLE_CYCLES=5, table {0x4110,0x9803,0x9AE0,0xD603}, model ACK=0.
  - Four transactions with I2C_DATA 0x724110, 0x729803, 0x729AE0, 0x72D603 in order.
  - CONFIG_DONE=1 and BUSY=0 after the last entry.
  - First I2C_GO rises exactly 11 cycles after RESET_N deasserts.
- NACK on index 2, first two attempts, RETRY_MAX=3:
  - Index 2 is issued three times, then the sequence completes.
  - CONFIG_DONE=1, CONFIG_ERROR=0.
- Persistent NACK on index 1, RETRY_MAX=3:
  - Four attempts at 0x729803, then CONFIG_ERROR=1 and ERR_INDEX=1.
  - Index 2 is never issued; I2C_GO stays 0.
- Model never raises I2C_END, TIMEOUT_CYCLES=50:
  - I2C_GO drops 50 cycles after rising; retry follows.
  - After RETRY_MAX+1 timeouts, CONFIG_ERROR=1, ERR_INDEX=0.
- REINIT pulse while in REQ on index 2:
  - I2C_GO drops next cycle; outputs clear and BUSY=1.
  - After I2C_END=0 and a 10-cycle delay, the sequence restarts at index 0 and completes.
- RESET_N asserted mid-REQ:
  - I2C_GO=0 and all outputs reach reset values without a clock edge.
  - After release, the full sequence replays from index 0.
